// File: rtl/input_request_handler.sv
// Input-instruction handler: synchronizes and debounces a confirm button, captures the switches on a press.
// Optional WAIT_PRESS timeout is compiled in when INPUT_TIMEOUT_EN is defined.
module input_request_handler #(
    parameter int IO_WIDTH        = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  request,
    input  logic                  sign_extend,
    input  logic [IO_WIDTH-1:0]   sw,
    input  logic                  confirm_button,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    output logic                  stall,
    output logic                  waiting_led,
    output logic                  timed_out
);

    typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1 || DATA_WIDTH <= IO_WIDTH) begin : g_param_check
        $error("input_request_handler: invalid parameter combination");
    end

    state_t            state;
    logic              sync1;
    logic              sync2;
    logic              btn_db;
    logic              btn_prev;
    logic [DB_W-1:0]   db_count;
    logic              btn_rise;
    logic              btn_fall;
    logic [DATA_WIDTH-1:0] captured;

    // The debounced level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            btn_db   <= 1'b0;
            btn_prev <= 1'b0;
            db_count <= '0;
        end else begin
            sync1    <= confirm_button;
            sync2    <= sync1;
            btn_prev <= btn_db;
            if (sync2 != btn_db) begin
                if (db_count == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    btn_db   <= sync2;
                    db_count <= '0;
                end else begin
                    db_count <= db_count + 1'b1;
                end
            end else begin
                db_count <= '0;
            end
        end
    end

    assign btn_rise = btn_db & ~btn_prev;
    assign btn_fall = ~btn_db & btn_prev;
    assign captured = {{(DATA_WIDTH - IO_WIDTH){sign_extend & sw[IO_WIDTH-1]}}, sw};

    assign stall = request & ~reset & (state != DONE);

`ifdef INPUT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_count;
`else
    assign timed_out = 1'b0;
`endif

    // Abort on a dropped request takes priority over a press, which takes priority over the timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            data        <= '0;
            data_valid  <= 1'b0;
            waiting_led <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
            timed_out   <= 1'b0;
            to_count    <= '0;
`endif
        end else begin
            data_valid  <= 1'b0;
            waiting_led <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
            to_count    <= '0;
`endif
            case (state)
                IDLE: begin
                    if (request) begin
                        state       <= WAIT_PRESS;
                        waiting_led <= 1'b1;
                    end
                end
                WAIT_PRESS: begin
                    if (!request) begin
                        state <= IDLE;
                    end else if (btn_rise) begin
                        data        <= captured;
                        state       <= WAIT_RELEASE;
                        waiting_led <= 1'b1;
`ifdef INPUT_TIMEOUT_EN
                        timed_out   <= 1'b0;
                    end else if (to_count == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        data       <= '0;
                        data_valid <= 1'b1;
                        timed_out  <= 1'b1;
                        state      <= DONE;
`endif
                    end else begin
                        waiting_led <= 1'b1;
`ifdef INPUT_TIMEOUT_EN
                        to_count    <= to_count + 1'b1;
`endif
                    end
                end
                WAIT_RELEASE: begin
                    if (!request) begin
                        state <= IDLE;
                    end else if (btn_fall) begin
                        state      <= DONE;
                        data_valid <= 1'b1;
                    end else begin
                        waiting_led <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_request_handler.sv
// Self-checking bench for input_request_handler: a queue-based button/transaction model checked every cycle,
// plus literal checks at key points. Timeout scenario runs only when INPUT_TIMEOUT_EN is defined.
module tb_input_request_handler;

    localparam int IO_W  = 16;
    localparam int DW    = 32;
    localparam int DEB   = 4;
    localparam int TMO   = 16;

    logic            clock;
    logic            reset;
    logic            request;
    logic            sign_extend;
    logic [IO_W-1:0] sw;
    logic            confirm_button;
    logic [DW-1:0]   data;
    logic            data_valid;
    logic            stall;
    logic            waiting_led;
    logic            timed_out;

    int vectors     = 0;
    int miscompares = 0;

    input_request_handler #(
        .IO_WIDTH(IO_W),
        .DATA_WIDTH(DW),
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .request(request),
        .sign_extend(sign_extend),
        .sw(sw),
        .confirm_button(confirm_button),
        .data(data),
        .data_valid(data_valid),
        .stall(stall),
        .waiting_led(waiting_led),
        .timed_out(timed_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model state: raw button history, synchronized samples since the last accepted level, transaction phase.
    bit          rawq[$];
    bit          syncq[$];
    bit          m_db;
    bit          m_db_prev;
    bit          m_rise;
    bit          m_fall;
    bit          m_all_diff;
    string       phase;
    logic [31:0] m_data;
    bit          m_to;
    int          m_wait;
    bit          model_ready = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            rawq        = '{1'b0, 1'b0};
            syncq.delete();
            m_db        = 1'b0;
            m_db_prev   = 1'b0;
            phase       = "idle";
            m_data      = '0;
            m_to        = 1'b0;
            m_wait      = 0;
            model_ready = 1'b1;
        end else if (model_ready) begin
            m_rise = m_db && !m_db_prev;
            m_fall = !m_db && m_db_prev;
            case (phase)
                "idle": begin
                    if (request) begin
                        phase  = "press";
                        m_wait = 0;
                    end
                end
                "press": begin
                    if (!request) begin
                        phase = "idle";
                    end else if (m_rise) begin
                        m_data = sign_extend ? {{16{sw[15]}}, sw} : {16'h0000, sw};
                        m_to   = 1'b0;
                        phase  = "release";
                    end else begin
                        m_wait++;
`ifdef INPUT_TIMEOUT_EN
                        if (m_wait == TMO) begin
                            phase  = "done";
                            m_data = '0;
                            m_to   = 1'b1;
                        end
`endif
                    end
                end
                "release": begin
                    if (!request) phase = "idle";
                    else if (m_fall) phase = "done";
                end
                default: phase = "idle";
            endcase
            // The synchronizer delays the raw button by two edges.
            syncq.push_back(rawq[rawq.size() - 2]);
            if (syncq.size() > DEB) void'(syncq.pop_front());
            m_all_diff = (syncq.size() == DEB);
            foreach (syncq[i]) if (syncq[i] == m_db) m_all_diff = 1'b0;
            m_db_prev = m_db;
            if (m_all_diff) begin
                m_db = !m_db;
                syncq.delete();
            end
            rawq.push_back(confirm_button);
            void'(rawq.pop_front());
        end
    end

    always @(posedge clock) begin
        #2;
        if (model_ready) begin
            check_output("data", data, m_data);
            check_output("data_valid", 32'(data_valid), 32'(phase == "done"));
            check_output("waiting_led", 32'(waiting_led), 32'(phase == "press" || phase == "release"));
            check_output("timed_out", 32'(timed_out), 32'(m_to));
            check_output("stall", 32'(stall), 32'(request && !reset && phase != "done"));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_valid(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clock);
            if (data_valid && cycles < 0) begin
                cycles = i;
                break;
            end
        end
    endtask

    // One full press/release transaction with the given switch word and extension mode.
    task automatic apply_stimulus(input logic [15:0] sw_val, input logic sext, input logic [31:0] expected, input string name);
        int cycles;
        sw          = sw_val;
        sign_extend = sext;
        request     = 1'b1;
        tick(2);
        check_output({name, " stall before press"}, 32'(stall), 32'd1);
        confirm_button = 1'b1;
        tick(20);
        confirm_button = 1'b0;
        wait_valid(20, cycles);
        check_output({name, " data_valid seen"}, 32'(cycles > 0), 32'd1);
        check_output({name, " data"}, data, expected);
        check_output({name, " stall in done"}, 32'(stall), 32'd0);
        request = 1'b0;
        tick(1);
        check_output({name, " data_valid one cycle"}, 32'(data_valid), 32'd0);
        tick(3);
    endtask

    initial begin
        int cycles;
        reset          = 1'b1;
        request        = 1'b0;
        sign_extend    = 1'b0;
        sw             = '0;
        confirm_button = 1'b0;
        tick(3);
        check_output("reset data", data, 32'h0);
        check_output("reset waiting_led", 32'(waiting_led), 32'd0);
        reset = 1'b0;
        tick(2);

        apply_stimulus(16'h8001, 1'b1, 32'hFFFF8001, "sext");
        apply_stimulus(16'h8001, 1'b0, 32'h00008001, "zext");

        // A 3-cycle glitch is shorter than the debounce window and must not capture.
        sw = 16'h1234; sign_extend = 1'b1; request = 1'b1;
        tick(3);
        confirm_button = 1'b1;
        tick(3);
        confirm_button = 1'b0;
        tick(15);
        check_output("glitch waiting_led", 32'(waiting_led), 32'd1);
        check_output("glitch stall", 32'(stall), 32'd1);
        check_output("glitch data", data, 32'h00008001);
        request = 1'b0;
        tick(3);

        // Request dropped after capture, while waiting for release.
        sw = 16'h7777; sign_extend = 1'b0; request = 1'b1;
        tick(2);
        confirm_button = 1'b1;
        tick(12);
        check_output("abort in release waiting_led", 32'(waiting_led), 32'd1);
        request = 1'b0;
        tick(1);
        check_output("abort waiting_led", 32'(waiting_led), 32'd0);
        check_output("abort data_valid", 32'(data_valid), 32'd0);
        check_output("abort data", data, 32'h00007777);
        confirm_button = 1'b0;
        tick(10);

        // Button already held when request rises must be released and pressed again.
        confirm_button = 1'b1;
        tick(10);
        sw = 16'h0042; sign_extend = 1'b1; request = 1'b1;
        tick(12);
        check_output("held no capture data", data, 32'h00007777);
        check_output("held waiting_led", 32'(waiting_led), 32'd1);
        confirm_button = 1'b0;
        tick(10);
        check_output("held release still waiting", 32'(waiting_led), 32'd1);
        confirm_button = 1'b1;
        tick(10);
        confirm_button = 1'b0;
        wait_valid(20, cycles);
        check_output("held data_valid seen", 32'(cycles > 0), 32'd1);
        check_output("held data", data, 32'h00000042);
        request = 1'b0;
        tick(3);

        // Reset in the middle of WAIT_PRESS.
        request = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        check_output("mid reset data", data, 32'h0);
        check_output("mid reset data_valid", 32'(data_valid), 32'd0);
        check_output("mid reset waiting_led", 32'(waiting_led), 32'd0);
        check_output("mid reset timed_out", 32'(timed_out), 32'd0);
        check_output("mid reset stall", 32'(stall), 32'd0);
        reset = 1'b0; request = 1'b0;
        tick(2);

`ifdef INPUT_TIMEOUT_EN
        sw = 16'hFFFF; sign_extend = 1'b1; request = 1'b1;
        wait_valid(40, cycles);
        check_output("timeout latency", 32'(cycles), 32'd17);
        check_output("timeout data", data, 32'h0);
        check_output("timeout timed_out", 32'(timed_out), 32'd1);
        request = 1'b0;
        tick(3);
        check_output("timeout timed_out holds", 32'(timed_out), 32'd1);
        apply_stimulus(16'h0005, 1'b0, 32'h00000005, "after timeout");
        check_output("capture clears timed_out", 32'(timed_out), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_request_handler.md
INPUT_REQUEST_HANDLER -- requirements
Module: input_request_handler

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- IO_WIDTH, 16, switch width.
- DATA_WIDTH, 32, processor data width.
- DEBOUNCE_CYCLES, 4, stable cycles required to accept a button level.
- TIMEOUT_CYCLES, 1024, wait limit used only under INPUT_TIMEOUT_EN.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clock, in, 1, single system clock; all state changes on its rising edge.
- reset, in, 1, synchronous, active-high.
- request, in, 1, processor is executing an input instruction.
- sign_extend, in, 1, 1 = sign-extend the captured value, 0 = zero-extend.
- sw, in, IO_WIDTH, raw switches.
- confirm_button, in, 1, raw asynchronous button, active-high.
- data, out, DATA_WIDTH, captured input word, feeds the processor input-data bus.
- data_valid, out, 1, data is fresh this cycle.
- stall, out, 1, processor holds its register-write enable low while 1.
- waiting_led, out, 1, user prompt.
- timed_out, out, 1, last delivery was a timeout.

Function
REQ-003 confirm_button SHALL pass through a 2-flop synchronizer, then a debouncer.
- Debounced level btn_db SHALL take the synchronized level only after that level has differed from btn_db for DEBOUNCE_CYCLES consecutive cycles.
- Any shorter deviation SHALL reset the debounce counter.
REQ-004 FSM states SHALL be IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
REQ-005 IDLE: request=1 -> WAIT_PRESS next cycle; otherwise remain.
REQ-006 WAIT_PRESS: a btn_db 0->1 edge SHALL capture sw into data and move to WAIT_RELEASE.
- A button already held when request rises SHALL NOT be accepted until it is released and pressed again.
REQ-007 Capture width rule: data[IO_WIDTH-1:0]=sw.
- Upper bits = sw[IO_WIDTH-1] when sign_extend=1, else 0.
- sign_extend is sampled in the capture cycle.
REQ-008 WAIT_RELEASE: a btn_db 1->0 edge SHALL move to DONE.
REQ-009 DONE SHALL last exactly one cycle and then go to IDLE.
- data_valid=1 only in DONE.
- A request still high in the following IDLE cycle SHALL start a new transaction.
REQ-010 stall SHALL equal request AND (state != DONE), combinationally, so the processor stalls in the same cycle request rises.
REQ-011 waiting_led SHALL be 1 in WAIT_PRESS and WAIT_RELEASE.
REQ-012 request falling in WAIT_PRESS or WAIT_RELEASE SHALL abort to IDLE next cycle.
- On abort, data SHALL remain unchanged and data_valid SHALL stay 0.
REQ-013 data SHALL hold its last captured value between transactions.

Reset
REQ-014 While reset=1 the following SHALL be forced at the next edge:
- state=IDLE; data=0; data_valid=0; timed_out=0.
- Synchronizer flops=0; btn_db=0; debounce and timeout counters=0.
REQ-015 Reset SHALL override every state, including mid-transaction.
- stall SHALL read 0 during reset regardless of request.

Configuration
REQ-016 Macro INPUT_TIMEOUT_EN, when defined, SHALL add a WAIT_PRESS timeout:
- The counter counts cycles spent in WAIT_PRESS.
- At TIMEOUT_CYCLES the FSM goes to DONE with data=0 and timed_out=1.
- timed_out holds until the next capture or reset.
- A button capture clears timed_out.
- The counter clears on leaving WAIT_PRESS.
REQ-017 Without INPUT_TIMEOUT_EN:
- No timeout counter SHALL be synthesized.
- timed_out SHALL be constant 0.
- WAIT_PRESS SHALL wait indefinitely.

Verification
REQ-018 Bench SHALL cover:
- sw=16'h8001, sign_extend=1, request=1, clean 20-cycle press then release -> data=32'hFFFF8001, one-cycle data_valid, stall=1 until DONE.
- Same as above with sign_extend=0 -> data=32'h00008001.
- 3-cycle button glitch with DEBOUNCE_CYCLES=4 -> no capture, state stays WAIT_PRESS, stall stays 1.
- Button held before request rises -> no capture; release then press with sw=16'h0042 -> data=32'h00000042.
- request dropped in WAIT_RELEASE -> IDLE next cycle, data unchanged, no data_valid; reset asserted in WAIT_PRESS -> all outputs 0 next cycle.
- INPUT_TIMEOUT_EN with TIMEOUT_CYCLES=16, no press -> DONE after 16 WAIT_PRESS cycles, data=0, timed_out=1.
